// File: rtl/read_buffer_responder.sv
// Responder side of the buffer read handshake: a circular FIFO filled by a producer.
// Each held read_req pops the oldest word and returns it with a one-cycle valid pulse.
module read_buffer_responder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              read_req,
  output logic              valid,
  output logic [DATA_W-1:0] rd_data
);

  typedef enum logic [1:0] {IDLE, LOAD, RESP, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              accept;
  logic              pop;

  // Flags come from the registered count, so a pop in LOAD cannot make room
  // for a write in the same cycle.
  assign full   = (count == DEPTH_CNT);
  assign empty  = (count == '0);
  assign accept = wr_en && !full;
  assign pop    = (state == LOAD);

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      count <= count + (ADDR_W+1)'(accept) - (ADDR_W+1)'(pop);
      valid <= 1'b0;
      case (state)
        IDLE: if (read_req && !empty) state <= LOAD;
        LOAD: begin
          rd_data <= mem[rd_ptr];
          rd_ptr  <= rd_ptr + 1'b1;
          valid   <= 1'b1;
          state   <= RESP;
        end
        RESP: state <= DONE;
        // One dead cycle lets the requester drop read_req after seeing valid.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_buffer_responder.sv
// Scoreboard bench for read_buffer_responder: accepted writes queue the expected
// word, every valid pulse pops and compares it.
module tb_read_buffer_responder;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              read_req;
  logic              valid;
  logic [DATA_W-1:0] rd_data;

  int checks    = 0;
  int failures  = 0;
  int mcnt      = 0;
  int valid_cnt = 0;
  logic prev_valid = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  read_buffer_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .read_req(read_req),
    .valid(valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every response must match the oldest accepted word.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        valid_cnt++;
        chk("valid_width", {31'd0, prev_valid}, 32'd0);
        if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else chk("rd_data", {16'd0, rd_data}, {16'd0, exp_q.pop_front()});
      end
      prev_valid = valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic push_word(input logic [DATA_W-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    if (mcnt < DEPTH) begin
      exp_q.push_back(d);
      mcnt++;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 20);
    chk("valid_timeout", {31'd0, valid}, 32'd1);
  endtask

  // Full request/response; returns with the responder back in IDLE.
  task automatic read_one(input int exp_lat);
    int n;
    read_req = 1'b1;
    wait_valid(n);
    read_req = 1'b0;
    mcnt--;
    if (exp_lat > 0) chk("latency", n, exp_lat);
    chk("count_after_pop", {28'd0, count}, mcnt);
    repeat (2) @(negedge clk);
  endtask

  // Read whose LOAD cycle also carries a producer write.
  task automatic read_load_write(input logic [DATA_W-1:0] d, input bit expect_accept);
    read_req = 1'b1;
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    if (expect_accept) exp_q.push_back(d);
    @(negedge clk);
    wr_en    = 1'b0;
    read_req = 1'b0;
    if (!expect_accept) mcnt--;
    chk("load_write_valid", {31'd0, valid}, 32'd1);
    chk("load_write_count", {28'd0, count}, mcnt);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [DATA_W-1:0] pat;
    int n;
    rst = 1'b1; wr_en = 1'b1; read_req = 1'b1; wr_data = 16'hFFFF;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_rd_data", {16'd0, rd_data}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0; wr_en = 1'b0; read_req = 1'b0;
    @(negedge clk);
    chk("post_rst_count", {28'd0, count}, 32'd0);

    // Basic read
    push_word(16'h0011);
    push_word(16'h0022);
    push_word(16'h0033);
    chk("basic_count", {28'd0, count}, 32'd3);
    repeat (3) read_one(2);
    chk("basic_empty", {31'd0, empty}, 32'd1);

    // Request while empty
    read_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_valid_while_empty", {31'd0, valid}, 32'd0);
    end
    push_word(16'h00AB);
    wait_valid(n);
    chk("empty_req_latency", n, 2);
    read_req = 1'b0;
    mcnt--;
    repeat (2) @(negedge clk);

    // Full and overflow, then pop from full with a write in LOAD
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    chk("full_flag", {31'd0, full}, 32'd1);
    chk("full_count", {28'd0, count}, 32'd8);
    chk("ovf_before", {31'd0, overflow}, 32'd0);
    push_word(16'h0009);
    chk("ovf_after", {31'd0, overflow}, 32'd1);
    chk("ovf_count", {28'd0, count}, 32'd8);
    read_load_write(16'h00EE, 1'b0);
    repeat (7) read_one(2);
    chk("drain_empty", {31'd0, empty}, 32'd1);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Wrap-around with simultaneous traffic
    pat = 16'h0100;
    push_word(pat); pat++;
    for (int k = 0; k < 19; k++) begin
      if (k % 2 == 0) begin
        read_load_write(pat, 1'b1); pat++;
      end else begin
        push_word(pat); pat++;
        read_one(2);
      end
    end
    read_one(2);
    chk("wrap_empty", {31'd0, empty}, 32'd1);

    // Reset in the LOAD cycle
    push_word(16'h0077);
    push_word(16'h0078);
    read_req = 1'b1;
    @(negedge clk);
    rst = 1'b1; read_req = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    mcnt = 0;
    repeat (3) @(negedge clk);
    chk("midrst_count", {28'd0, count}, 32'd0);
    chk("midrst_empty", {31'd0, empty}, 32'd1);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    push_word(16'h0055);
    read_one(2);

    chk("queue_drained", exp_q.size(), 0);
    chk("total_valids", valid_cnt, 33);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
